// File: rtl/lock_pkg.sv
// Shared types for the digital-lock button front end.
// Pure declarations; no timing or flow control.
package lock_pkg;

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        RISE_CHK = 2'd1,
        HIGH     = 2'd2,
        FALL_CHK = 2'd3
    } btn_state_t;

    // Counter width able to hold 0..samples inclusive.
    function automatic int cnt_width(input int samples);
        return $clog2(samples + 1);
    endfunction

endpackage

// File: rtl/button_debouncer_channel.sv
// One debounced button: synchroniser plus tick-sampled accept/reject FSM.
// Latency SYNC_STAGES clk + STABLE_SAMPLES ticks; no backpressure, strobes are one clk wide.
module debounce_channel #(
    parameter int STABLE_SAMPLES = 3,
    parameter int SYNC_STAGES    = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);
    import lock_pkg::*;

    localparam int CW = cnt_width(STABLE_SAMPLES);
    localparam logic [CW-1:0] LAST = CW'(STABLE_SAMPLES - 1);

    if (STABLE_SAMPLES < 1) begin : g_bad_samples
        $error("debounce_channel: STABLE_SAMPLES must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("debounce_channel: SYNC_STAGES must be >= 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    btn_state_t             state;
    logic [CW-1:0]          cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // A check state is left either by confirming the new level on the
    // STABLE_SAMPLES-th matching sample or by falling back on any mismatch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= LOW;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            if (tick) begin
                case (state)
                    LOW: begin
                        if (sync) begin
                            if (STABLE_SAMPLES == 1) begin
                                state     <= HIGH;
                                cnt       <= '0;
                                btn_level <= 1'b1;
                                btn_press <= 1'b1;
                            end else begin
                                state <= RISE_CHK;
                                cnt   <= CW'(1);
                            end
                        end
                    end
                    RISE_CHK: begin
                        if (!sync) begin
                            state <= LOW;
                            cnt   <= '0;
                        end else if (cnt == LAST) begin
                            state     <= HIGH;
                            cnt       <= '0;
                            btn_level <= 1'b1;
                            btn_press <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    HIGH: begin
                        if (!sync) begin
                            if (STABLE_SAMPLES == 1) begin
                                state       <= LOW;
                                cnt         <= '0;
                                btn_level   <= 1'b0;
                                btn_release <= 1'b1;
                            end else begin
                                state <= FALL_CHK;
                                cnt   <= CW'(1);
                            end
                        end
                    end
                    FALL_CHK: begin
                        if (sync) begin
                            state <= HIGH;
                            cnt   <= '0;
                        end else if (cnt == LAST) begin
                            state       <= LOW;
                            cnt         <= '0;
                            btn_level   <= 1'b0;
                            btn_release <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state     <= LOW;
                        cnt       <= '0;
                        btn_level <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// N_BTN independent debounced buttons sharing one sample tick.
// Latency SYNC_STAGES clk + STABLE_SAMPLES ticks; no backpressure, strobes are one clk wide.
module button_debouncer #(
    parameter int N_BTN          = 4,
    parameter int STABLE_SAMPLES = 3,
    parameter int SYNC_STAGES    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        debounce_channel #(
            .STABLE_SAMPLES (STABLE_SAMPLES),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .tick        (tick),
            .btn_in      (btn_in[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i])
        );
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench: stimulus queues expected strobes keyed by tick index, a monitor pops on every strobe.
module tb_button_debouncer;

    typedef struct {
        int       tk;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] lvl;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       tick;
    logic [3:0] btn_in;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;

    int   errors   = 0;
    int   checks   = 0;
    int   tick_idx = 0;
    exp_t sb[$];
    exp_t e;

    button_debouncer #(
        .N_BTN          (4),
        .STABLE_SAMPLES (3),
        .SYNC_STAGES    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        tick = 1'b0;
        forever begin
            repeat (9) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (tick) tick_idx++;
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (tick %0d)", name, act, req, tick_idx);
        end
    endtask

    always @(negedge clk) begin
        if ((btn_press | btn_release) != 4'h0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: press=%h release=%h at tick %0d, expected none",
                         btn_press, btn_release, tick_idx);
            end else begin
                e = sb.pop_front();
                check("strobe_tick", tick_idx, e.tk);
                check("press", int'(btn_press), int'(e.press));
                check("release", int'(btn_release), int'(e.rel));
                check("level", int'(btn_level), int'(e.lvl));
            end
        end
    end

    // Return on the falling edge just after a tick edge.
    task automatic sync_to_tick();
        @(posedge clk);
        while (!tick) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_ev(input int dt, input logic [3:0] p, input logic [3:0] r,
                             input logic [3:0] l);
        exp_t x;
        x.tk = tick_idx + dt;
        x.press = p;
        x.rel = r;
        x.lvl = l;
        sb.push_back(x);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d strobes still pending, expected 0", name, sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        btn_in = 4'hF;
        repeat (25) @(negedge clk);
        check("rst_level", int'(btn_level), 0);
        check("rst_press", int'(btn_press), 0);
        check("rst_release", int'(btn_release), 0);

        // Buttons already held when reset lifts: press on the 3rd tick.
        sync_to_tick();
        rst = 1'b0;
        expect_ev(3, 4'hF, 4'h0, 4'hF);
        drain("post_rst_press");
        check("post_rst_level", int'(btn_level), 'hF);

        sync_to_tick();
        btn_in = 4'h0;
        expect_ev(3, 4'h0, 4'hF, 4'h0);
        drain("all_release");
        check("all_release_level", int'(btn_level), 0);

        // Clean press on channel 0, held 50 cycles, then released.
        sync_to_tick();
        btn_in = 4'h1;
        expect_ev(3, 4'h1, 4'h0, 4'h1);
        repeat (50) @(negedge clk);
        check("clean_sb_empty", sb.size(), 0);
        check("clean_level", int'(btn_level), 'h1);
        sync_to_tick();
        btn_in = 4'h0;
        expect_ev(3, 4'h0, 4'h1, 4'h0);
        drain("clean_release");
        check("clean_release_level", int'(btn_level), 0);

        // Bounce on channel 1: two high samples, one low, then three high.
        sync_to_tick();
        btn_in = 4'h2;
        expect_ev(6, 4'h2, 4'h0, 4'h2);
        sync_to_tick();
        sync_to_tick();
        btn_in = 4'h0;
        sync_to_tick();
        check("bounce_level_mid", int'(btn_level), 0);
        btn_in = 4'h2;
        drain("bounce_press");
        check("bounce_level", int'(btn_level), 'h2);
        sync_to_tick();
        btn_in = 4'h0;
        expect_ev(3, 4'h0, 4'h2, 4'h0);
        drain("bounce_release");

        // Glitch on channel 0 entirely between two ticks.
        sync_to_tick();
        repeat (3) @(negedge clk);
        btn_in = 4'h1;
        repeat (2) @(negedge clk);
        btn_in = 4'h0;
        repeat (40) @(negedge clk);
        check("glitch_level", int'(btn_level), 0);

        // Simultaneous press on channels 2 and 3.
        sync_to_tick();
        btn_in = 4'hC;
        expect_ev(3, 4'hC, 4'h0, 4'hC);
        drain("simul_press");
        sync_to_tick();
        btn_in = 4'h0;
        expect_ev(3, 4'h0, 4'hC, 4'h0);
        drain("simul_release");

        // Reset while channel 0 sits in RISE_CHK with cnt=2.
        sync_to_tick();
        btn_in = 4'h1;
        sync_to_tick();
        sync_to_tick();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_level", int'(btn_level), 0);
        check("midrst_press", int'(btn_press), 0);
        rst = 1'b0;
        // Three fresh ticks needed after the remainder of this tick period.
        expect_ev(3, 4'h1, 4'h0, 4'h1);
        drain("midrst_press");
        check("midrst_final_level", int'(btn_level), 'h1);
        sync_to_tick();
        btn_in = 4'h0;
        expect_ev(3, 4'h0, 4'h1, 4'h0);
        drain("midrst_release");

        check("sb_empty_end", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
